// File: rtl/plru_tracker_if.sv
// Request/response bundle between a cache controller and plru_tracker.
//   flush/busy            : start a full clear of all PLRU state / sweep in progress
//   rd_en/rindex/rvalid   : victim lookup request with the set's valid bits
//   victim_way/valid      : registered lookup result (valid is a one-cycle strobe)
//   touch_en/windex/way   : mark a way most-recently-used
// master = cache controller side, slave = tracker side.
interface plru_tracker_if #(
    parameter int S_INDEX   = 3,
    parameter int WAYS_LOG2 = 2
);
    localparam int NUM_WAYS = 2 ** WAYS_LOG2;

    logic                 flush;
    logic                 busy;
    logic                 rd_en;
    logic [S_INDEX-1:0]   rindex;
    logic [NUM_WAYS-1:0]  rvalid_ways;
    logic [WAYS_LOG2-1:0] victim_way;
    logic                 victim_valid;
    logic                 touch_en;
    logic [S_INDEX-1:0]   windex;
    logic [WAYS_LOG2-1:0] touch_way;

    modport master (
        output flush, rd_en, rindex, rvalid_ways, touch_en, windex, touch_way,
        input  busy, victim_way, victim_valid
    );

    modport slave (
        input  flush, rd_en, rindex, rvalid_ways, touch_en, windex, touch_way,
        output busy, victim_way, victim_valid
    );
endinterface

// File: rtl/plru_tracker.sv
// Per-set tree pseudo-LRU tracker for a set-associative cache.
// Each set holds NUM_WAYS-1 tree bits; node (level l, prefix p) lives at
// bit 2**l - 1 + p, and a 1 steers the victim toward the upper half.
// Lookups return a registered victim one cycle after rd_en, see a touch to the
// same set in the same cycle, and optionally prefer the lowest invalid way.
// A flush pulse starts a sweep clearing one set per cycle while busy is high.
// Ports: clk, rst (async, active-high), bus (plru_tracker_if.slave).
module plru_tracker #(
    parameter int S_INDEX       = 3,
    parameter int WAYS_LOG2     = 2,
    parameter bit INVALID_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst,
    plru_tracker_if.slave bus
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int NUM_WAYS = 2 ** WAYS_LOG2;
    localparam int NODES    = NUM_WAYS - 1;

    typedef logic [NODES-1:0]     tree_t;
    typedef logic [WAYS_LOG2-1:0] way_t;
    typedef logic [S_INDEX-1:0]   set_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

    // Point every node on the touched way's path away from that way.
    function automatic tree_t touch_tree(input tree_t t, input way_t w);
        tree_t r;
        way_t  node;
        r = t;
        for (int l = 0; l < WAYS_LOG2; l++) begin
            node    = way_t'((1 << l) - 1) + way_t'(w >> (WAYS_LOG2 - l));
            r[node] = ~w[WAYS_LOG2-1-l];
        end
        return r;
    endfunction

    // Walk from the root; each chosen bit selects the next node on the path.
    function automatic way_t plru_victim(input tree_t t);
        way_t v;
        way_t node;
        v = '0;
        for (int l = 0; l < WAYS_LOG2; l++) begin
            node             = way_t'((1 << l) - 1) + way_t'(v >> (WAYS_LOG2 - l));
            v[WAYS_LOG2-1-l] = t[node];
        end
        return v;
    endfunction

    // Lowest-index invalid way wins over the PLRU choice when enabled.
    function automatic way_t pick_victim(input tree_t t, input logic [NUM_WAYS-1:0] valid);
        way_t v;
        v = plru_victim(t);
        if (INVALID_FIRST) begin
            for (int i = NUM_WAYS - 1; i >= 0; i--) begin
                if (!valid[i]) begin
                    v = way_t'(i);
                end
            end
        end
        return v;
    endfunction

    tree_t  tree_r [NUM_SETS];
    state_t state_r, state_next_s;
    set_t   cnt_r, cnt_next_s;
    logic   busy_r;
    way_t   victim_way_r;
    logic   victim_valid_r;

    logic   idle_s, rd_acc_s, touch_acc_s;
    tree_t  tree_wr_s, tree_rd_s;
    way_t   victim_s;

    // Request acceptance, touched tree value and the (bypassed) lookup result.
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        rd_acc_s    = bus.rd_en & idle_s;
        touch_acc_s = bus.touch_en & idle_s;
        tree_wr_s   = touch_tree(tree_r[bus.windex], bus.touch_way);
        if (touch_acc_s && (bus.windex == bus.rindex)) begin
            tree_rd_s = tree_wr_s;
        end else begin
            tree_rd_s = tree_r[bus.rindex];
        end
        victim_s = pick_victim(tree_rd_s, bus.rvalid_ways);
    end

    // Flush FSM next-state: idle until flush, then one set per cycle.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.flush) begin
                    state_next_s = ST_SWEEP;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (cnt_r == set_t'(NUM_SETS - 1)) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s = cnt_r + set_t'(1'b1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // FSM state, sweep counter and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == ST_SWEEP);
        end
    end

    // Tree storage: sweep clears, otherwise accepted touches update one set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_r[s] <= '0;
            end
        end else if (state_r == ST_SWEEP) begin
            tree_r[cnt_r] <= '0;
        end else if (touch_acc_s) begin
            tree_r[bus.windex] <= tree_wr_s;
        end
    end

    // Registered victim; way holds between lookups, valid is a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_way_r   <= '0;
            victim_valid_r <= 1'b0;
        end else begin
            victim_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                victim_way_r <= victim_s;
            end
        end
    end

    assign bus.busy         = busy_r;
    assign bus.victim_way   = victim_way_r;
    assign bus.victim_valid = victim_valid_r;
endmodule
